// File: rtl/uart_pix_pkg.sv
// Shared types and defaults for the UART-byte-to-pixel write controller.
package uart_pix_pkg;

  typedef enum logic [1:0] {
    S_B0 = 2'd0,
    S_B1 = 2'd1,
    S_B2 = 2'd2
  } byte_state_e;

  localparam int BYTES_PER_PIX   = 3;
  localparam int PIX_W           = 8 * BYTES_PER_PIX;
  localparam int DEF_IMG_W       = 100;
  localparam int DEF_IMG_H       = 100;
  localparam int DEF_ADDR_W      = 14;
  localparam int DEF_TIMEOUT_CYC = 104166;

endpackage

// File: rtl/uart_pix_wr_ctrl_if.sv
// Frame-buffer write port: request held until wr_en && wr_ready.
interface uart_pix_wr_ctrl_if
  import uart_pix_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) ();

  logic              wr_en;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [PIX_W-1:0]  wr_data;

  modport master (output wr_en, output wr_addr, output wr_data, input wr_ready);
  modport slave  (input wr_en, input wr_addr, input wr_data, output wr_ready);

endinterface

// File: rtl/pix_byte_timeout.sv
// Idle counter for a partially received pixel; timeout fires on the
// TIMEOUT_CYC-th consecutive idle cycle while active.
module pix_byte_timeout
  import uart_pix_pkg::*;
#(
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic active,
  input  logic po_flag,
  output logic timeout
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    timeout = active && !po_flag && (cnt_q == CNT_LAST);
    cnt_d   = cnt_q + CNT_W'(1);
    if (!active || po_flag || timeout) cnt_d = '0;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_pix_wr_ctrl.sv
// Packs three UART bytes into one pixel write; write issues the cycle after the
// third byte and holds until wr_ready. Optional idle timeout under UART_PIX_TIMEOUT_EN.
module uart_pix_wr_ctrl
  import uart_pix_pkg::*;
#(
  parameter int IMG_W       = DEF_IMG_W,
  parameter int IMG_H       = DEF_IMG_H,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic [7:0]          po_data,
  input  logic                po_flag,
  input  logic                clr,
  uart_pix_wr_ctrl_if.master  wr,
  output logic                frame_done,
  output logic                ovf
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_W * IMG_H - 1);

  if ((IMG_W * IMG_H > 2 ** ADDR_W) || (TIMEOUT_CYC < 1)) begin : g_cfg_err
    $error("uart_pix_wr_ctrl: invalid IMG_W/IMG_H/ADDR_W/TIMEOUT_CYC");
  end

  byte_state_e       state_q, state_d;
  logic [7:0]        slot0_q, slot0_d, slot1_q, slot1_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [PIX_W-1:0]  wr_data_q, wr_data_d;
  logic              ovf_q, ovf_d;
  logic              timeout_hit, accept, pix_done;

`ifdef UART_PIX_TIMEOUT_EN
  pix_byte_timeout #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .active  (state_q != S_B0),
    .po_flag (po_flag),
    .timeout (timeout_hit)
  );
`else
  assign timeout_hit = 1'b0;
`endif

  assign accept     = wr_en_q & wr.wr_ready;
  assign pix_done   = po_flag & (state_q == S_B2);
  assign frame_done = accept & (wr_addr_q == LAST_ADDR);

  always_comb begin
    state_d   = state_q;
    slot0_d   = slot0_q;
    slot1_d   = slot1_q;
    wr_en_d   = wr_en_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    ovf_d     = ovf_q;

    unique case (state_q)
      S_B0: if (po_flag) begin
        slot0_d = po_data;
        state_d = S_B1;
      end
      S_B1: if (po_flag) begin
        slot1_d = po_data;
        state_d = S_B2;
      end else if (timeout_hit) begin
        slot0_d = '0;
        state_d = S_B0;
      end
      S_B2: if (po_flag) begin
        state_d = S_B0;
      end else if (timeout_hit) begin
        slot0_d = '0;
        slot1_d = '0;
        state_d = S_B0;
      end
      default: state_d = S_B0;
    endcase

    if (accept) begin
      wr_en_d   = 1'b0;
      wr_addr_d = (wr_addr_q == LAST_ADDR) ? '0 : wr_addr_q + ADDR_W'(1);
    end

    // A pixel finishing while the previous write is still stalled is dropped.
    if (pix_done) begin
      if (!wr_en_q || accept) begin
        wr_en_d   = 1'b1;
        wr_data_d = {slot0_q, slot1_q, po_data};
      end else begin
        ovf_d = 1'b1;
      end
    end

    if (clr) begin
      state_d   = S_B0;
      slot0_d   = '0;
      slot1_d   = '0;
      wr_en_d   = 1'b0;
      wr_addr_d = '0;
      wr_data_d = '0;
      ovf_d     = 1'b0;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q   <= S_B0;
      slot0_q   <= '0;
      slot1_q   <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      slot0_q   <= slot0_d;
      slot1_q   <= slot1_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      ovf_q     <= ovf_d;
    end
  end

  assign wr.wr_en   = wr_en_q;
  assign wr.wr_addr = wr_addr_q;
  assign wr.wr_data = wr_data_q;
  assign ovf        = ovf_q;

endmodule

// File: tb/tb_uart_pix_wr_ctrl.sv
// Bench for uart_pix_wr_ctrl: directed scenarios plus randomized traffic
// against a byte-queue / pending-write reference model.
module tb_uart_pix_wr_ctrl;
  import uart_pix_pkg::*;

  localparam int IMG_W       = 2;
  localparam int IMG_H       = 2;
  localparam int ADDR_W      = 4;
  localparam int TIMEOUT_CYC = 100;
  localparam int NPIX        = IMG_W * IMG_H;

  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic [7:0] po_data = '0;
  logic       po_flag = 1'b0;
  logic       clr     = 1'b0;
  logic       frame_done, ovf;

  uart_pix_wr_ctrl_if #(.ADDR_W(ADDR_W)) wr ();

  uart_pix_wr_ctrl #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .po_data    (po_data),
    .po_flag    (po_flag),
    .clr        (clr),
    .wr         (wr),
    .frame_done (frame_done),
    .ovf        (ovf)
  );

  always #5 sys_clk = ~sys_clk;

  int checks = 0;
  int errors = 0;

  // Reference model: bytes of the pixel in progress, the one pending write,
  // the next frame address and the sticky overflow flag.
  logic [7:0]  m_bytes[$];
  bit          m_pend;
  bit          m_ovf;
  int          m_next;
  int          m_idle;
  int          m_acc_cnt;
  logic [23:0] m_data;

  // Observed accepted writes and frame_done pulses.
  logic [ADDR_W+23:0] act_q[$];
  int                 fd_cnt;
  logic [ADDR_W-1:0]  fd_addr;

  always @(negedge sys_clk) begin
    if (!sys_rst) begin
      if (wr.wr_en && wr.wr_ready) act_q.push_back({wr.wr_addr, wr.wr_data});
      if (frame_done) begin
        fd_cnt++;
        fd_addr = wr.wr_addr;
      end
    end
  end

  task automatic model_reset();
    m_bytes.delete();
    m_pend = 1'b0;
    m_ovf  = 1'b0;
    m_next = 0;
    m_idle = 0;
  endtask

  // One clock cycle: drive inputs, compare outputs with the model, advance the model.
  task automatic step(input bit f, input logic [7:0] d, input bit rdy, input bit c);
    bit          acc, fd_exp;
    logic [23:0] pix;
    po_flag     = f;
    po_data     = d;
    wr.wr_ready = rdy;
    clr         = c;
    @(negedge sys_clk);
    acc    = m_pend && rdy;
    fd_exp = acc && (m_next == NPIX - 1);
    checks++;
    if (wr.wr_en !== m_pend || wr.wr_addr !== ADDR_W'(m_next) ||
        (m_pend && wr.wr_data !== m_data) || ovf !== m_ovf || frame_done !== fd_exp) begin
      errors++;
      $display("FAIL cycle_model t=%0t en=%b exp %b addr=%0d exp %0d data=%h exp %h ovf=%b exp %b fd=%b exp %b",
               $time, wr.wr_en, m_pend, wr.wr_addr, m_next, wr.wr_data, m_data,
               ovf, m_ovf, frame_done, fd_exp);
    end
    if (acc) begin
      m_pend = 1'b0;
      m_next = (m_next + 1) % NPIX;
      m_acc_cnt++;
    end
    if (c) begin
      model_reset();
    end else begin
`ifdef UART_PIX_TIMEOUT_EN
      if (f) m_idle = 0;
      else if (m_bytes.size() > 0) begin
        m_idle++;
        if (m_idle == TIMEOUT_CYC) begin
          m_bytes.delete();
          m_idle = 0;
        end
      end
`endif
      if (f) begin
        m_bytes.push_back(d);
        if (m_bytes.size() == BYTES_PER_PIX) begin
          pix = {m_bytes[0], m_bytes[1], m_bytes[2]};
          m_bytes.delete();
          if (!m_pend) begin
            m_pend = 1'b1;
            m_data = pix;
          end else begin
            m_ovf = 1'b1;
          end
        end
      end
    end
    @(posedge sys_clk);
    #1;
    po_flag = 1'b0;
    clr     = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input bit rdy);
    step(1'b1, b, rdy, 1'b0);
    step(1'b0, 8'h00, rdy, 1'b0);
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(1'b0, 8'($urandom), rdy, 1'b0);
  endtask

  task automatic restart();
    step(1'b0, 8'h00, 1'b1, 1'b1);
    act_q.delete();
    fd_cnt = 0;
  endtask

  task automatic test_reset();
    sys_rst     = 1'b1;
    wr.wr_ready = 1'b1;
    repeat (3) @(posedge sys_clk);
    #1;
    checks++;
    if (wr.wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en got %b want 0", wr.wr_en); end
    checks++;
    if (wr.wr_addr !== '0) begin errors++; $display("FAIL reset_wr_addr got %0d want 0", wr.wr_addr); end
    checks++;
    if (wr.wr_data !== '0) begin errors++; $display("FAIL reset_wr_data got %h want 0", wr.wr_data); end
    checks++;
    if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done got %b want 0", frame_done); end
    checks++;
    if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", ovf); end
    sys_rst = 1'b0;
    model_reset();
    m_acc_cnt = 0;
    act_q.delete();
    fd_cnt = 0;
  endtask

  task automatic test_basic_write();
    restart();
    send(8'h11, 1'b1);
    send(8'h22, 1'b1);
    send(8'h33, 1'b1);
    idle(4, 1'b1);
    checks++;
    if (act_q.size() != 1) begin errors++; $display("FAIL basic_count got %0d want 1", act_q.size()); end
    else begin
      checks++;
      if (act_q[0] !== {ADDR_W'(0), 24'h112233})
        begin errors++; $display("FAIL basic_write got %h want %h", act_q[0], {ADDR_W'(0), 24'h112233}); end
    end
  endtask

  task automatic test_frame_wrap();
    logic [7:0] b[15];
    restart();
    for (int i = 0; i < 15; i++) b[i] = 8'($urandom);
    for (int i = 0; i < 12; i++) send(b[i], 1'b1);
    idle(3, 1'b1);
    checks++;
    if (act_q.size() != 4) begin errors++; $display("FAIL wrap_count got %0d want 4", act_q.size()); end
    else begin
      for (int p = 0; p < 4; p++) begin
        checks++;
        if (act_q[p] !== {ADDR_W'(p), b[3*p], b[3*p+1], b[3*p+2]})
          begin errors++; $display("FAIL wrap_write%0d got %h want %h", p, act_q[p], {ADDR_W'(p), b[3*p], b[3*p+1], b[3*p+2]}); end
      end
    end
    checks++;
    if (fd_cnt != 1 || fd_addr !== ADDR_W'(NPIX - 1))
      begin errors++; $display("FAIL wrap_frame_done got cnt %0d addr %0d want cnt 1 addr %0d", fd_cnt, fd_addr, NPIX - 1); end
    for (int i = 12; i < 15; i++) send(b[i], 1'b1);
    idle(2, 1'b1);
    checks++;
    if (act_q.size() != 5 || act_q[act_q.size()-1] !== {ADDR_W'(0), b[12], b[13], b[14]})
      begin errors++; $display("FAIL wrap_next_addr got n=%0d last %h want addr 0", act_q.size(), act_q[act_q.size()-1]); end
  endtask

  task automatic test_backpressure();
    restart();
    for (int i = 1; i <= 6; i++) send(8'hA0 + 8'(i), 1'b0);
    checks++;
    if (ovf !== 1'b1) begin errors++; $display("FAIL bp_ovf got %b want 1", ovf); end
    checks++;
    if (wr.wr_en !== 1'b1 || wr.wr_data !== 24'hA1A2A3 || wr.wr_addr !== '0)
      begin errors++; $display("FAIL bp_hold got en %b data %h addr %0d want 1 a1a2a3 0", wr.wr_en, wr.wr_data, wr.wr_addr); end
    checks++;
    if (act_q.size() != 0) begin errors++; $display("FAIL bp_stalled got %0d writes want 0", act_q.size()); end
    idle(4, 1'b1);
    checks++;
    if (act_q.size() != 1 || act_q[0] !== {ADDR_W'(0), 24'hA1A2A3})
      begin errors++; $display("FAIL bp_release got n=%0d first %h want 1 write at 0 a1a2a3", act_q.size(), act_q[0]); end
    checks++;
    if (ovf !== 1'b1) begin errors++; $display("FAIL bp_ovf_sticky got %b want 1", ovf); end
    restart();
    checks++;
    if (ovf !== 1'b0) begin errors++; $display("FAIL bp_ovf_clr got %b want 0", ovf); end
  endtask

  task automatic test_timeout();
    logic [23:0] want;
`ifdef UART_PIX_TIMEOUT_EN
    want = 24'h010203;
`else
    want = 24'hAA0102;
`endif
    restart();
    step(1'b1, 8'hAA, 1'b1, 1'b0);
    idle(TIMEOUT_CYC, 1'b1);
    send(8'h01, 1'b1);
    send(8'h02, 1'b1);
    send(8'h03, 1'b1);
    idle(2, 1'b1);
    checks++;
    if (act_q.size() != 1 || act_q[0][23:0] !== want)
      begin errors++; $display("FAIL timeout_data got n=%0d data %h want 1 write %h", act_q.size(), act_q[0][23:0], want); end
  endtask

  task automatic test_clr_priority();
    restart();
    send(8'h31, 1'b1); send(8'h32, 1'b1); send(8'h33, 1'b1);
    send(8'h41, 1'b1); send(8'h42, 1'b1);
    step(1'b1, 8'h43, 1'b1, 1'b1);
    idle(3, 1'b1);
    checks++;
    if (act_q.size() != 1 || wr.wr_en !== 1'b0 || wr.wr_addr !== '0)
      begin errors++; $display("FAIL clr_no_write got n=%0d en %b addr %0d want 1 0 0", act_q.size(), wr.wr_en, wr.wr_addr); end
    send(8'h05, 1'b1); send(8'h06, 1'b1); send(8'h07, 1'b1);
    idle(2, 1'b1);
    checks++;
    if (act_q.size() != 2 || act_q[1] !== {ADDR_W'(0), 24'h050607})
      begin errors++; $display("FAIL clr_next_write got n=%0d last %h want addr 0 050607", act_q.size(), act_q[act_q.size()-1]); end
  endtask

  task automatic test_reset_mid();
    restart();
    send(8'h51, 1'b1); send(8'h52, 1'b1); send(8'h53, 1'b1);
    send(8'h61, 1'b1);
    sys_rst = 1'b1;
    @(posedge sys_clk);
    #1;
    checks++;
    if (wr.wr_en !== 1'b0 || wr.wr_addr !== '0 || wr.wr_data !== '0 || ovf !== 1'b0 || frame_done !== 1'b0)
      begin errors++; $display("FAIL rst_mid_outputs got en %b addr %0d data %h ovf %b fd %b want all 0", wr.wr_en, wr.wr_addr, wr.wr_data, ovf, frame_done); end
    sys_rst = 1'b0;
    model_reset();
    send(8'h71, 1'b1); send(8'h72, 1'b1); send(8'h73, 1'b1);
    idle(2, 1'b1);
    checks++;
    if (act_q.size() != 2 || act_q[1] !== {ADDR_W'(0), 24'h717273})
      begin errors++; $display("FAIL rst_mid_next got n=%0d last %h want addr 0 717273", act_q.size(), act_q[act_q.size()-1]); end
    send(8'h81, 1'b0); send(8'h82, 1'b0); send(8'h83, 1'b0);
    sys_rst = 1'b1;
    @(posedge sys_clk);
    #1;
    sys_rst = 1'b0;
    model_reset();
    idle(5, 1'b1);
    checks++;
    if (act_q.size() != 2) begin errors++; $display("FAIL rst_pending_drop got %0d writes want 2", act_q.size()); end
  endtask

  task automatic test_random();
    int acc0;
    restart();
    acc0 = m_acc_cnt;
    for (int i = 0; i < 800; i++)
      step($urandom_range(0, 2) == 0, 8'($urandom), 1'($urandom_range(0, 1)), $urandom_range(0, 99) == 0);
    idle(4, 1'b1);
    checks++;
    if (act_q.size() != m_acc_cnt - acc0)
      begin errors++; $display("FAIL random_write_count got %0d want %0d", act_q.size(), m_acc_cnt - acc0); end
  endtask

  initial begin
    m_acc_cnt = 0;
    fd_cnt    = 0;
    model_reset();
    test_reset();
    test_basic_write();
    test_frame_wrap();
    test_backpressure();
    test_timeout();
    test_clr_priority();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
